mcu_reset_sequencer: RTL and testbench

Reset controller sitting between the clock source, the board reset button and the MCU51 core. It holds the core's active-high RST until the 12 MHz clock is locked and stable. It then releases RST after a fixed hold time, re-sequences reset on a debounced button press, a watchdog timeout or loss of clock lock, and records the cause of the last reset. All logic runs in the 12 MHz core clock domain.

---
 rtl/mcu_reset_sequencer.sv | 175 +++++++++++++++++
 tb/tb_mcu_reset_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_reset_sequencer.sv
// rtl/mcu_reset_sequencer.sv - MCU51 reset sequencer: lock wait, reset hold, button/watchdog/clock-loss re-reset
// Holds the core in reset until the clock is locked and records the cause of the last reset.
module mcu_reset_sequencer #(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int RST_HOLD        = 48,
  parameter int WDT_CYCLES      = 1200000,
  parameter int WDT_EN          = 1
) (
  input  logic       CLK,
  input  logic       resetn,
  input  logic       clk_locked,
  input  logic       btn_reset,
  input  logic       wdt_kick,
  output logic       mcu_rst,
  output logic       run,
  output logic [1:0] rst_cause
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int WDT_W  = $clog2(WDT_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [WDT_W-1:0]  WDT_LAST  = WDT_W'(WDT_CYCLES - 1);

  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;
  localparam logic [1:0] CAUSE_CLK = 2'b11;

  typedef enum logic [1:0] {
    S_POR_WAIT = 2'd0,
    S_HOLD     = 2'd1,
    S_RUN      = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]        r_lock_sync;
  logic [1:0]        r_btn_sync;
  logic [1:0]        r_kick_sync;
  logic              r_kick_prev;
  logic              r_deb;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [WDT_W-1:0]  r_wdt_cnt;
  logic [1:0]        r_cause;
  logic [1:0]        w_cause;
  logic              r_mcu_rst;
  logic              r_run;

  logic w_lock;
  logic w_btn;
  logic w_kick;
  logic w_deb_flip;
  logic w_press;
  logic w_hold_done;
  logic w_wdt_exp;

  // Bit [1] of each synchronizer is the stage the rest of the logic uses.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_lock_sync <= 2'b00;
      r_btn_sync  <= 2'b00;
      r_kick_sync <= 2'b00;
      r_kick_prev <= 1'b0;
    end else begin
      r_lock_sync <= {r_lock_sync[0], clk_locked};
      r_btn_sync  <= {r_btn_sync[0], btn_reset};
      r_kick_sync <= {r_kick_sync[0], wdt_kick};
      r_kick_prev <= r_kick_sync[1];
    end
  end

  assign w_lock = r_lock_sync[1];
  assign w_btn  = r_btn_sync[1];
  assign w_kick = r_kick_sync[1] ^ r_kick_prev;

  // The press event is taken on the same edge that flips the debounced level.
  assign w_deb_flip = (w_btn != r_deb) && (r_deb_cnt == DEB_LAST);
  assign w_press    = w_deb_flip && !r_deb;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_deb     <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      if (w_deb_flip) begin
        r_deb <= !r_deb;
      end
      if (w_btn == r_deb || w_deb_flip) begin
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  assign w_hold_done = (r_hold_cnt == HOLD_LAST) && !r_deb;
  assign w_wdt_exp   = (WDT_EN != 0) && (r_state == S_RUN) && (r_wdt_cnt == WDT_LAST) && !w_kick;

  always_comb begin
    w_next  = r_state;
    w_cause = r_cause;
    case (r_state)
      S_POR_WAIT: begin
        if (w_lock) begin
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!w_lock) begin
          w_next  = S_POR_WAIT;
          w_cause = CAUSE_CLK;
        end else if (w_hold_done) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!w_lock) begin
          w_next  = S_POR_WAIT;
          w_cause = CAUSE_CLK;
        end else if (w_wdt_exp) begin
          w_next  = S_HOLD;
          w_cause = CAUSE_WDT;
        end else if (w_press) begin
          w_next  = S_HOLD;
          w_cause = CAUSE_BTN;
        end
      end
      default: begin
        w_next = S_POR_WAIT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_POR_WAIT;
      r_cause   <= 2'b00;
      r_mcu_rst <= 1'b1;
      r_run     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cause   <= w_cause;
      r_mcu_rst <= (w_next != S_RUN);
      r_run     <= (w_next == S_RUN);
    end
  end

  // Both counters restart whenever their state is (re)entered.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_hold_cnt <= '0;
      r_wdt_cnt  <= '0;
    end else begin
      if (r_state != S_HOLD || w_next != S_HOLD || r_deb) begin
        r_hold_cnt <= '0;
      end else if (r_hold_cnt != HOLD_LAST) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
      if (WDT_EN == 0 || r_state != S_RUN || w_next != S_RUN || w_kick) begin
        r_wdt_cnt <= '0;
      end else if (r_wdt_cnt != WDT_LAST) begin
        r_wdt_cnt <= r_wdt_cnt + 1'b1;
      end
    end
  end

  assign mcu_rst   = r_mcu_rst;
  assign run       = r_run;
  assign rst_cause = r_cause;

endmodule

// File: tb/tb_mcu_reset_sequencer.sv
// tb/tb_mcu_reset_sequencer.sv - directed and randomized check of mcu_reset_sequencer against a timer model
module tb_mcu_reset_sequencer;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int WDT  = 20;

  logic       CLK = 1'b0;
  logic       resetn;
  logic       clk_locked;
  logic       btn_reset;
  logic       wdt_kick;
  logic       mcu_rst;
  logic       run;
  logic [1:0] rst_cause;
  logic       d2_mcu_rst;
  logic       d2_run;
  logic [1:0] d2_rst_cause;

  int n_pass  = 0;
  int n_total = 0;
  int cycle   = 0;
  bit auto_kick = 1'b0;

  always #5 CLK = ~CLK;

  mcu_reset_sequencer #(
    .DEBOUNCE_CYCLES(DEB), .RST_HOLD(HOLD), .WDT_CYCLES(WDT), .WDT_EN(1)
  ) dut (
    .CLK(CLK), .resetn(resetn), .clk_locked(clk_locked), .btn_reset(btn_reset),
    .wdt_kick(wdt_kick), .mcu_rst(mcu_rst), .run(run), .rst_cause(rst_cause)
  );

  mcu_reset_sequencer #(
    .DEBOUNCE_CYCLES(DEB), .RST_HOLD(HOLD), .WDT_CYCLES(WDT), .WDT_EN(0)
  ) dut_nowdt (
    .CLK(CLK), .resetn(resetn), .clk_locked(clk_locked), .btn_reset(btn_reset),
    .wdt_kick(wdt_kick), .mcu_rst(d2_mcu_rst), .run(d2_run), .rst_cause(d2_rst_cause)
  );

  // Reference: pins seen two edges late, core in reset or not, countdown timers.
  bit         q_lock[$];
  bit         q_btn[$];
  bit         q_kick[$];
  bit         m_last_kick;
  bit         m_deb;
  bit         m_rst;
  bit         m_wait_lock;
  int         m_mism;
  int         m_hold_left;
  int         m_wdt_left;
  logic [1:0] m_cause;

  task automatic model_reset();
    q_lock = {}; q_btn = {}; q_kick = {};
    repeat (2) begin
      q_lock.push_back(1'b0); q_btn.push_back(1'b0); q_kick.push_back(1'b0);
    end
    m_last_kick = 1'b0; m_deb = 1'b0; m_mism = 0;
    m_rst = 1'b1; m_wait_lock = 1'b1; m_hold_left = 0; m_wdt_left = 0;
    m_cause = 2'b00;
  endtask

  task automatic model_step();
    bit lk, b, kk, kick, press, old_deb;
    lk = q_lock.pop_front(); q_lock.push_back(clk_locked);
    b  = q_btn.pop_front();  q_btn.push_back(btn_reset);
    kk = q_kick.pop_front(); q_kick.push_back(wdt_kick);
    kick = (kk != m_last_kick);
    m_last_kick = kk;
    old_deb = m_deb;
    press = 1'b0;
    if (b != m_deb) begin
      m_mism++;
      if (m_mism == DEB) begin
        m_deb = b; m_mism = 0; press = b;
      end
    end else begin
      m_mism = 0;
    end
    if (!m_rst) begin
      if (!lk) begin
        m_rst = 1'b1; m_wait_lock = 1'b1; m_cause = 2'b11;
      end else if (m_wdt_left == 1 && !kick) begin
        m_rst = 1'b1; m_wait_lock = 1'b0; m_hold_left = HOLD; m_cause = 2'b10;
      end else if (press) begin
        m_rst = 1'b1; m_wait_lock = 1'b0; m_hold_left = HOLD; m_cause = 2'b01;
      end else begin
        m_wdt_left = kick ? WDT : m_wdt_left - 1;
      end
    end else if (m_wait_lock) begin
      if (lk) begin
        m_wait_lock = 1'b0; m_hold_left = HOLD;
      end
    end else begin
      if (!lk) begin
        m_wait_lock = 1'b1; m_cause = 2'b11;
      end else if (old_deb) begin
        m_hold_left = HOLD;
      end else if (m_hold_left == 1) begin
        m_rst = 1'b0; m_wdt_left = WDT;
      end else begin
        m_hold_left--;
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cycle);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    cycle++;
    #1;
    chk("cycle_outputs", int'({mcu_rst, run, rst_cause}), int'({m_rst, !m_rst, m_cause}));
    if (auto_kick && (cycle % 8 == 0)) wdt_kick = ~wdt_kick;
  endtask

  task automatic wait_rst(input logic lvl, input int bound, output int n);
    n = 0;
    while (mcu_rst !== lvl && n < bound) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, observed cycle %0d", cycle);
    $fatal(1);
  end

  initial begin
    int n;
    int kick_rate;
    resetn = 1'b0; clk_locked = 1'b0; btn_reset = 1'b0; wdt_kick = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_state", int'({mcu_rst, run, rst_cause}), 8);
    chk("reset_state_nowdt", int'({d2_mcu_rst, d2_run, d2_rst_cause}), 8);
    resetn = 1'b1;
    auto_kick = 1'b1;

    // Power-on
    repeat (5) tick();
    chk("por_wait_rst", int'({mcu_rst, rst_cause}), 4);
    clk_locked = 1'b1;
    wait_rst(1'b0, 40, n);
    chk("por_release_latency", n, 3 + HOLD);
    chk("por_run_cause", int'({run, rst_cause}), 4);

    // Button
    btn_reset = 1'b1; tick(); tick(); btn_reset = 1'b0;
    repeat (10) tick();
    chk("btn_glitch_ignored", int'(run), 1);
    btn_reset = 1'b1;
    wait_rst(1'b1, 20, n);
    chk("btn_press_latency", n, 2 + DEB);
    chk("btn_cause", int'(rst_cause), 1);
    repeat (4) tick();
    btn_reset = 1'b0;
    wait_rst(1'b0, 40, n);
    chk("btn_release_reached", int'(mcu_rst), 0);
    btn_reset = 1'b1;
    repeat (30) tick();
    chk("btn_long_held", int'(mcu_rst), 1);
    btn_reset = 1'b0;
    wait_rst(1'b0, 40, n);
    chk("btn_long_release_latency", n, 2 + DEB + HOLD);

    // Watchdog
    auto_kick = 1'b0;
    for (int i = 0; i < 13; i++) begin
      wdt_kick = ~wdt_kick;
      repeat (15) tick();
    end
    chk("wdt_kicked_no_reset", int'(run), 1);
    wdt_kick = ~wdt_kick;
    wait_rst(1'b1, 60, n);
    chk("wdt_expiry_latency", n, 3 + WDT);
    chk("wdt_cause", int'(rst_cause), 2);
    chk("wdt_disabled_no_reset", int'({d2_mcu_rst, d2_run, d2_rst_cause}), 5);
    wait_rst(1'b0, 40, n);
    chk("wdt_hold_len", n, HOLD);
    auto_kick = 1'b1;

    // Clock loss
    clk_locked = 1'b0;
    wait_rst(1'b1, 20, n);
    chk("clk_loss_latency", n, 3);
    chk("clk_loss_cause", int'(rst_cause), 3);
    repeat (6) tick();
    clk_locked = 1'b1;
    wait_rst(1'b0, 40, n);
    chk("relock_latency", n, 3 + HOLD);
    chk("relock_cause_kept", int'(rst_cause), 3);

    // Priority: clock loss and watchdog expiry on the same edge
    auto_kick = 1'b0;
    wdt_kick = ~wdt_kick;
    repeat (20) tick();
    clk_locked = 1'b0;
    repeat (3) tick();
    chk("prio_clk_over_wdt", int'({mcu_rst, rst_cause}), 7);
    clk_locked = 1'b1;
    wait_rst(1'b0, 40, n);
    chk("prio_relock_reached", int'(mcu_rst), 0);

    // Kick on the expiry cycle wins
    wdt_kick = ~wdt_kick;
    repeat (20) tick();
    wdt_kick = ~wdt_kick;
    repeat (5) tick();
    chk("kick_beats_expiry", int'(run), 1);
    wait_rst(1'b1, 40, n);
    chk("kick_restart_latency", n, 3 + WDT - 5);
    chk("kick_restart_cause", int'(rst_cause), 2);
    wait_rst(1'b0, 40, n);
    auto_kick = 1'b1;

    // Asynchronous reset mid-HOLD and mid-RUN
    clk_locked = 1'b0;
    repeat (4) tick();
    clk_locked = 1'b1;
    repeat (5) tick();
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_hold", int'({mcu_rst, run, rst_cause}), 8);
    model_reset();
    resetn = 1'b1;
    wait_rst(1'b0, 40, n);
    chk("after_async_release", n, 3 + HOLD);
    repeat (3) tick();
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_run", int'({mcu_rst, run, rst_cause}), 8);
    model_reset();
    resetn = 1'b1;

    // Randomized traffic against the model
    auto_kick = 1'b0;
    kick_rate = 10;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) kick_rate = ($urandom_range(0, 1) == 0) ? 10 : 45;
      if (clk_locked ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 19) == 0))
        clk_locked = ~clk_locked;
      if ($urandom_range(0, 6) == 0) btn_reset = ~btn_reset;
      if ($urandom_range(0, kick_rate - 1) == 0) wdt_kick = ~wdt_kick;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
